// File: rtl/reg_dump_ctrl_pkg.sv
// Shared types for the register-dump debug path: FSM encoding, debug command codes
// and word/byte geometry.
package reg_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3,
    S_DONE    = 3'd4
  } dump_state_e;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_DUMP = 2'd1,
    CMD_STEP = 2'd2,
    CMD_RUN  = 2'd3
  } dbg_cmd_e;

  function automatic int bytes_per_word(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

endpackage

// File: rtl/reg_dump_ctrl_word_serializer.sv
// Holds one register word and presents it a byte at a time, LSB byte first;
// o_last marks the final byte of the word.
module reg_dump_ctrl_word_serializer
  import reg_dump_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_word,
  input  logic                  i_advance,
  output logic [BYTE_WIDTH-1:0] o_byte,
  output logic                  o_last
);

  localparam int BPW = bytes_per_word(DATA_WIDTH, BYTE_WIDTH);
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [DATA_WIDTH-1:0] word_q;
  logic [CW-1:0]         byte_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_q   <= '0;
      byte_cnt <= '0;
    end else if (i_load) begin
      word_q   <= i_word;
      byte_cnt <= '0;
    end else if (i_advance && !o_last) begin
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign o_byte = word_q[int'(byte_cnt)*BYTE_WIDTH +: BYTE_WIDTH];
  assign o_last = (byte_cnt == CW'(BPW - 1));

endmodule

// File: rtl/reg_dump_ctrl.sv
// Register-file read-port arbiter: decode stage owns the ports normally; while the
// pipeline is halted a debug dump walks every register out to the UART byte by byte.
module reg_dump_ctrl
  import reg_dump_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int P_REG_WIDTH = 5,
  parameter int NUM_REGS    = 32,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_halted,
  input  logic [P_REG_WIDTH-1:0] i_pipe_rs,
  input  logic [P_REG_WIDTH-1:0] i_pipe_rt,
  input  logic                   i_pipe_read_en,
  input  logic [DATA_WIDTH-1:0]  i_rf_data1,
  output logic [P_REG_WIDTH-1:0] o_rf_rs,
  output logic [P_REG_WIDTH-1:0] o_rf_rt,
  output logic                   o_rf_read_en,
  output logic [BYTE_WIDTH-1:0]  o_tx_data,
  output logic                   o_tx_valid,
  input  logic                   i_tx_ready,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_abort
);

  dump_state_e            state;
  logic [P_REG_WIDTH-1:0] reg_cnt;
  logic [BYTE_WIDTH-1:0]  ser_byte;
  logic                   ser_last;
  logic                   tx_fire;

  assign tx_fire = o_tx_valid && i_tx_ready;

  reg_dump_ctrl_word_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .BYTE_WIDTH(BYTE_WIDTH)
  ) u_ser (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_load   (state == S_CAPTURE),
    .i_word   (i_rf_data1),
    .i_advance(tx_fire),
    .o_byte   (ser_byte),
    .o_last   (ser_last)
  );

  // Losing the halt outranks everything but reset: the pipeline must get its ports back.
  always_ff @(posedge i_clk) begin
    o_done  <= 1'b0;
    o_abort <= 1'b0;
    if (i_reset) begin
      state      <= S_IDLE;
      reg_cnt    <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else if (state != S_IDLE && !i_halted) begin
      state      <= S_IDLE;
      o_abort    <= 1'b1;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start && i_halted) begin
          state   <= S_READ;
          reg_cnt <= '0;
          o_busy  <= 1'b1;
        end
        S_READ:    state <= S_CAPTURE;
        S_CAPTURE: begin
          state      <= S_SEND;
          o_tx_valid <= 1'b1;
        end
        S_SEND: if (tx_fire && ser_last) begin
          o_tx_valid <= 1'b0;
          if (reg_cnt < P_REG_WIDTH'(NUM_REGS - 1)) begin
            reg_cnt <= reg_cnt + 1'b1;
            state   <= S_READ;
          end else begin
            state  <= S_DONE;
            o_done <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_rf_rs      = i_pipe_rs;
    o_rf_rt      = i_pipe_rt;
    o_rf_read_en = i_pipe_read_en;
    if (o_busy) begin
      o_rf_rs      = reg_cnt;
      o_rf_rt      = '0;
      o_rf_read_en = (state == S_READ);
    end
  end

  assign o_tx_data = o_tx_valid ? ser_byte : '0;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Randomized bench for reg_dump_ctrl: a register-file model feeds the DUT and the
// expected byte stream is built from the register contents, LSB byte first.
module tb_reg_dump_ctrl;
  localparam int DW = 32, RW = 5, NR = 32, BW = 8;
  localparam int NB = NR * (DW / BW);

  logic          i_clk = 1'b0, i_reset = 1'b1, i_start = 1'b0, i_halted = 1'b0;
  logic          i_pipe_read_en = 1'b0, i_tx_ready = 1'b0;
  logic [RW-1:0] i_pipe_rs = '0, i_pipe_rt = '0;
  logic [DW-1:0] i_rf_data1 = '0;
  logic [RW-1:0] o_rf_rs, o_rf_rt;
  logic          o_rf_read_en, o_tx_valid, o_busy, o_done, o_abort;
  logic [BW-1:0] o_tx_data;

  always #5 i_clk = ~i_clk;

  reg_dump_ctrl #(.DATA_WIDTH(DW), .P_REG_WIDTH(RW), .NUM_REGS(NR), .BYTE_WIDTH(BW)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_halted(i_halted),
    .i_pipe_rs(i_pipe_rs), .i_pipe_rt(i_pipe_rt), .i_pipe_read_en(i_pipe_read_en),
    .i_rf_data1(i_rf_data1), .o_rf_rs(o_rf_rs), .o_rf_rt(o_rf_rt), .o_rf_read_en(o_rf_read_en),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .o_busy(o_busy), .o_done(o_done), .o_abort(o_abort));

  // Register file with one-cycle read latency
  logic [DW-1:0] rf [NR];
  always @(posedge i_clk) if (o_rf_read_en) i_rf_data1 <= rf[o_rf_rs];

  int n_tests = 0, n_fail = 0, cyc = 0;
  int byte_cnt, done_cnt, abort_cnt, read_idx, s_cyc, first_cyc, done_cyc, last_cyc;
  int ready_mode = 0;
  bit first_seen, pend_valid, prev_rst;
  logic [BW-1:0] pend_data;
  logic [BW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Sink readiness: 0 always, 1 one-high/three-low, 2 random, 3 held low
  initial forever begin
    @(posedge i_clk);
    #1;
    case (ready_mode)
      0: i_tx_ready = 1'b1;
      1: i_tx_ready = (cyc % 4) == 0;
      2: i_tx_ready = 1'($urandom_range(0, 1));
      default: i_tx_ready = 1'b0;
    endcase
  end

  initial forever begin
    @(negedge i_clk);
    if (o_tx_valid && !first_seen) begin first_seen = 1; first_cyc = cyc; end
    if (pend_valid && !o_abort && !prev_rst) begin
      chk("hold_valid", o_tx_valid, 1);
      chk("hold_data", o_tx_data, pend_data);
    end
    if (o_tx_valid && i_tx_ready) begin
      if (exp_q.size() != 0) chk("tx_byte", o_tx_data, exp_q.pop_front());
      byte_cnt++;
      last_cyc = cyc;
    end
    if (o_busy && o_rf_read_en) begin
      chk("rd_addr", o_rf_rs, read_idx);
      chk("rd_rt", o_rf_rt, 0);
      read_idx++;
    end
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (o_abort) abort_cnt++;
    pend_valid = o_tx_valid && !i_tx_ready;
    pend_data  = o_tx_data;
    prev_rst   = i_reset;
  end

  task automatic start_dump();
    exp_q.delete();
    for (int r = 0; r < NR; r++)
      for (int b = 0; b < DW / BW; b++) exp_q.push_back(BW'(rf[r] >> (BW * b)));
    byte_cnt = 0; done_cnt = 0; abort_cnt = 0; read_idx = 0; first_seen = 0;
    @(posedge i_clk); #1 i_start = 1'b1; s_cyc = cyc;
    @(posedge i_clk); #1 i_start = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    while (done_cnt + abort_cnt == 0 && n < budget) begin @(posedge i_clk); n++; end
    chk("finished_in_budget", 32'(n < budget), 1);
    repeat (3) @(posedge i_clk);
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (byte_cnt < target && n < 2000) begin @(posedge i_clk); n++; end
    chk("reached_byte", 32'(byte_cnt >= target), 1);
  endtask

  task automatic chk_full();
    chk("byte_total", byte_cnt, NB);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("aborts", abort_cnt, 0);
    chk("done_lat", done_cyc - last_cyc, 1);
  endtask

  task automatic fill_random();
    rf[0] = '0;
    for (int k = 1; k < NR; k++) rf[k] = $urandom();
  endtask

  initial begin
    i_pipe_rs = 7; i_pipe_rt = 3; i_pipe_read_en = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", o_tx_valid, 0); chk("rst_data", o_tx_data, 0);
    chk("rst_busy", o_busy, 0); chk("rst_done", o_done, 0); chk("rst_abort", o_abort, 0);
    chk("rst_mux_rs", o_rf_rs, i_pipe_rs); chk("rst_mux_rt", o_rf_rt, i_pipe_rt);
    chk("rst_mux_en", o_rf_read_en, i_pipe_read_en);
    @(posedge i_clk); #1 i_reset = 1'b0; i_halted = 1'b1;

    // Full dump, sink always ready
    for (int k = 0; k < NR; k++) rf[k] = 32'h1111_1111 * k;
    ready_mode = 0;
    start_dump(); wait_end(1000); chk_full();
    chk("first_valid_lat", first_cyc - s_cyc, 3);
    chk("done_cycle", done_cyc - s_cyc, 6 * NR + 1);

    // Backpressure 1 high / 3 low, then random
    fill_random(); rf[5] = 32'hDEAD_BEEF;
    ready_mode = 1;
    start_dump(); wait_end(3000); chk_full();
    fill_random();
    ready_mode = 2;
    start_dump(); wait_end(3000); chk_full();

    // Start without halt is ignored
    i_halted = 1'b0; i_pipe_rs = RW'($urandom_range(1, NR - 1)); byte_cnt = 0;
    @(posedge i_clk); #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    repeat (5) @(posedge i_clk);
    @(negedge i_clk);
    chk("nohalt_busy", o_busy, 0); chk("nohalt_valid", o_tx_valid, 0);
    chk("nohalt_rs", o_rf_rs, i_pipe_rs); chk("nohalt_en", o_rf_read_en, i_pipe_read_en);
    chk("nohalt_bytes", byte_cnt, 0);

    // Halt drops while R10 byte 2 is pending
    i_halted = 1'b1; i_pipe_rs = 7; ready_mode = 0; fill_random();
    start_dump(); wait_bytes(42);
    #2 ready_mode = 3; i_tx_ready = 1'b0; i_halted = 1'b0;
    @(posedge i_clk); @(negedge i_clk);
    chk("abort_pulse", o_abort, 1); chk("abort_busy", o_busy, 0); chk("abort_valid", o_tx_valid, 0);
    chk("abort_mux_rs", o_rf_rs, i_pipe_rs); chk("abort_mux_en", o_rf_read_en, i_pipe_read_en);
    chk("abort_bytes", byte_cnt, 42); chk("abort_no_done", done_cnt, 0);
    @(negedge i_clk);
    chk("abort_one_cycle", o_abort, 0);
    @(posedge i_clk); #1 i_halted = 1'b1; ready_mode = 2;

    // Reset mid-dump at R20, then a clean dump from R0
    fill_random();
    start_dump(); wait_bytes(80);
    #2 i_reset = 1'b1;
    @(negedge i_clk); @(negedge i_clk);
    chk("mrst_valid", o_tx_valid, 0); chk("mrst_data", o_tx_data, 0); chk("mrst_busy", o_busy, 0);
    chk("mrst_done", o_done, 0); chk("mrst_abort", o_abort, 0);
    @(posedge i_clk); #1 i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    chk("mrst_no_done", done_cnt, 0); chk("mrst_no_abort", abort_cnt, 0);
    start_dump(); wait_end(3000); chk_full();

    // Second start mid-dump is ignored
    fill_random();
    start_dump();
    repeat (40) @(posedge i_clk);
    #1 i_start = 1'b1;
    @(posedge i_clk); #1 i_start = 1'b0;
    wait_end(3000); chk_full();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
